ia_bitserial_driver: RTL

- Front-end driver for one CIM column: accepts a job of NROWS multi-bit input activations and streams them LSB-first as the 1b-per-row `ia` vector.
- Generates the pipeline-aligned accumulator `shift` for the column.
- Recovers the job's dot-product by differencing the column's free-running accumulator `sum` before and after the job, so no accumulator clear is needed.
- Sits between the activation buffer and the column.

---
 rtl/ia_bitserial_driver_if.sv | 24 ++
 rtl/ia_bitserial_driver.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ia_bitserial_driver_if.sv
// Job-side handshake bundle for ia_bitserial_driver.
// slave = driver view, master = job source / result sink.
interface ia_bitserial_driver_if #(
  parameter int NROWS  = 64,
  parameter int ACTLEN = 8,
  parameter int SUMW   = 17
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NROWS-1:0][ACTLEN-1:0]  act;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [SUMW-1:0]        result;

  modport master (
    output in_valid, act, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, act, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/ia_bitserial_driver.sv
// Bit-serial CIM column driver: streams activations LSB-first, aligns shift,
// and differences col_sum around a job. SIGNED_ACT_EN selects signed acts.
module ia_bitserial_driver #(
  parameter int NROWS   = 64,
  parameter int ACTLEN  = 8,
  parameter int SHIFTW  = 8,
  parameter int SUMW    = 17,
  parameter int COL_LAT = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  ia_bitserial_driver_if.slave   job,
  output logic [NROWS-1:0]       ia,
  output logic [SHIFTW-1:0]      shift,
  input  logic signed [SUMW-1:0] col_sum,
  output logic                   busy
);

  localparam int CMAX = (ACTLEN > COL_LAT) ? ACTLEN : COL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                       state_q;
  state_t                       state_d;
  logic [CW-1:0]                cnt_q;
  logic [NROWS-1:0][ACTLEN-1:0] sr_q;
  logic signed [SUMW-1:0]       base_q;
  logic signed [SUMW-1:0]       result_q;
  logic [SHIFTW-1:0]            idx1_q;
  logic [SHIFTW-1:0]            shift_q;
  logic signed [SUMW-1:0]       diff;
  logic signed [SUMW-1:0]       final_sum;
  logic                         accept;
  logic                         last_stream;
  logic                         last_drain;

  assign accept      = (state_q == IDLE) && job.in_valid;
  assign last_stream = (cnt_q == CW'(ACTLEN - 1));
  assign last_drain  = (cnt_q == CW'(COL_LAT - 1));
  assign diff        = col_sum - base_q;

`ifdef SIGNED_ACT_EN
  logic signed [SUMW-1:0] mid_q;
  logic signed [SUMW-1:0] msb_part;

  // MSB weight is negative: remove its positive contribution twice.
  assign msb_part  = col_sum - mid_q;
  assign final_sum = diff - (msb_part <<< 1);
`else
  assign final_sum = diff;
`endif

  assign shift      = shift_q;
  assign job.result = result_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    job.in_ready  = 1'b0;
    job.out_valid = 1'b0;
    busy          = 1'b1;
    ia            = '0;
    unique case (state_q)
      IDLE: begin
        job.in_ready = 1'b1;
        busy         = 1'b0;
        if (job.in_valid) state_d = STREAM;
      end
      STREAM: begin
        for (int r = 0; r < NROWS; r++) ia[r] = sr_q[r][0];
        if (last_stream) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_drain) state_d = DONE;
      end
      DONE: begin
        job.out_valid = 1'b1;
        if (job.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: activation shifter, counter, shift pipe, base/result capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      base_q   <= '0;
      result_q <= '0;
      idx1_q   <= '0;
      shift_q  <= '0;
`ifdef SIGNED_ACT_EN
      mid_q    <= '0;
`endif
    end else begin
      idx1_q  <= (state_q == STREAM) ? SHIFTW'(cnt_q) : '0;
      shift_q <= idx1_q;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q   <= job.act;
            base_q <= col_sum;
            cnt_q  <= '0;
          end
        end
        STREAM: begin
          for (int r = 0; r < NROWS; r++) sr_q[r] <= sr_q[r] >> 1;
          cnt_q <= last_stream ? '0 : cnt_q + CW'(1);
        end
        DRAIN: begin
          cnt_q <= last_drain ? '0 : cnt_q + CW'(1);
`ifdef SIGNED_ACT_EN
          if (cnt_q == CW'(COL_LAT - 2)) mid_q <= col_sum;
`endif
          if (last_drain) result_q <= final_sum;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
